multicycle_controller: RTL and testbench

Main control FSM for the multi-cycle RV32I core. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives ALUOp into the ALU operation decoder and drives the datapath mux selects, write enables and memory request strobes. Instruction and data memory both use a req/ready handshake.

---
 rtl/ctrl_pkg.sv | 56 +++++
 rtl/mem_wait_timer.sv | 48 ++++
 rtl/multicycle_controller.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes,
// and the ALUOp / pc_src / wb_sel / ALU operand select codes the datapath decodes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_BR   = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    localparam logic SRCB_RS2 = 1'b0;
    localparam logic SRCB_IMM = 1'b1;

    // Opcodes that need an EXEC cycle; FENCE/SYSTEM retire straight from DECODE.
    function automatic logic is_exec_op(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_exec_op = 1'b1;
            default:                           is_exec_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request waits un-acked; flags a timeout at MAX_WAIT
// (MAX_WAIT = 0 disables it) and keeps a sticky bus_err until reset.
module mem_wait_timer #(
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              waiting_i,
    input  logic              ready_i,
    output logic              timeout_o,
    output logic              bus_err_o,
    output logic [WAIT_W-1:0] wait_cnt_o
);

    localparam logic              TO_EN   = (MAX_WAIT != 0);
    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              bus_err_q, bus_err_d;

    // A ready in the timeout cycle wins, so ready_i masks the timeout.
    assign timeout_o = TO_EN && waiting_i && !ready_i && (wait_cnt_q == MAX_CNT);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!waiting_i || ready_i || timeout_o) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != '1) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        bus_err_d = bus_err_q | timeout_o;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign bus_err_o  = bus_err_q;
    assign wait_cnt_o = wait_cnt_q;

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core (FETCH/DECODE/EXEC/MEM/WB).
// Define RV_CTRL_TRAP_EN to park illegal opcodes in TRAP instead of retiring them as NOP.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       imem_ready,
    input  logic [6:0] instr_opcode,
    input  logic       dmem_ready,
    input  logic       br_taken,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] ALUOp,
    output logic [1:0] alu_src_a,
    output logic       alu_src_b,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       bus_err,
    output logic       trap,
    output logic [2:0] state_o
);

    state_e      state_q, state_d;
    logic [6:0]  op_q, op_d;
    logic        waiting, ready_mux, timeout;
    logic [WAIT_W-1:0] wait_cnt;

    // Only the ack belonging to the current wait state reaches the timer.
    assign waiting   = (state_q == S_FETCH) || (state_q == S_MEM);
    assign ready_mux = (state_q == S_FETCH) ? imem_ready : dmem_ready;

    mem_wait_timer #(
        .WAIT_W   (WAIT_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .waiting_i  (waiting),
        .ready_i    (ready_mux),
        .timeout_o  (timeout),
        .bus_err_o  (bus_err),
        .wait_cnt_o (wait_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RST;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    op_d    = instr_opcode;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (is_exec_op(op_q)) begin
                    state_d = S_EXEC;
                end else if (op_q == OP_FENCE || op_q == OP_SYSTEM) begin
                    state_d = S_FETCH;
                end else begin
`ifdef RV_CTRL_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                if (op_q == OP_LOAD || op_q == OP_STORE) begin
                    state_d = S_MEM;
                end else if (op_q == OP_BRANCH) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    state_d = (op_q == OP_LOAD) ? S_WB : S_FETCH;
                end else if (timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_PLUS4;
        ALUOp     = ALU_ADD;
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                pc_write = imem_ready;
            end
            S_EXEC: begin
                case (op_q)
                    OP_R:    ALUOp = ALU_FUNC;
                    OP_I: begin
                        ALUOp     = ALU_FUNC;
                        alu_src_b = SRCB_IMM;
                    end
                    OP_LOAD, OP_STORE: alu_src_b = SRCB_IMM;
                    OP_AUIPC: begin
                        alu_src_a = SRCA_PC;
                        alu_src_b = SRCB_IMM;
                    end
                    OP_LUI: begin
                        ALUOp     = ALU_PASS;
                        alu_src_a = SRCA_ZERO;
                        alu_src_b = SRCB_IMM;
                    end
                    OP_BRANCH: begin
                        ALUOp    = ALU_BR;
                        pc_write = br_taken;
                        pc_src   = PC_TARGET;
                    end
                    OP_JAL: begin
                        ALUOp    = ALU_PASS;
                        pc_write = 1'b1;
                        pc_src   = PC_TARGET;
                    end
                    OP_JALR: begin
                        alu_src_b = SRCB_IMM;
                        pc_write  = 1'b1;
                        pc_src    = PC_JALR;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_q == OP_STORE);
            end
            S_WB: begin
                reg_write = 1'b1;
                if (op_q == OP_LOAD) begin
                    wb_sel = WB_LOAD;
                end else if (op_q == OP_JAL || op_q == OP_JALR) begin
                    wb_sel = WB_PC4;
                end
            end
            default: ;
        endcase
    end

`ifdef RV_CTRL_TRAP_EN
    assign trap = (state_q == S_TRAP);
`else
    assign trap = 1'b0;
`endif

    assign state_o = state_q;

    // Counter value is exposed by the timer for debug only.
    logic unused_wait_cnt;
    assign unused_wait_cnt = ^wait_cnt;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller (MAX_WAIT=4 instance);
// covers both builds of RV_CTRL_TRAP_EN.
module tb_multicycle_controller;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       imem_ready, dmem_ready, br_taken;
    logic [6:0] instr_opcode;
    logic       imem_req, dmem_req, dmem_we, ir_write, pc_write;
    logic [1:0] pc_src, ALUOp, alu_src_a, wb_sel;
    logic       alu_src_b, reg_write, bus_err, trap;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_pass   = 0;

    // per-instruction observations
    int         cyc, n_rw, n_dreq, n_dwe, n_pcw;
    logic [1:0] wb_rec, ex_aluop, ex_a, ex_pcsrc;
    logic       ex_b, ex_pcw;

    multicycle_controller #(.WAIT_W(8), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset), .imem_ready(imem_ready), .instr_opcode(instr_opcode),
        .dmem_ready(dmem_ready), .br_taken(br_taken), .imem_req(imem_req),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .ALUOp(ALUOp), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .reg_write(reg_write), .wb_sel(wb_sel), .bus_err(bus_err), .trap(trap),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] all_outs();
        return {17'd0, imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, ALUOp,
                alu_src_a, alu_src_b, reg_write, wb_sel, trap};
    endfunction

    // Runs one instruction from FETCH until FETCH is re-entered, recording strobes.
    task automatic run_instr(input logic [6:0] op, input int imem_dly, input int dmem_dly,
                             input logic br);
        int   k_f, k_m;
        logic left, done;
        k_f = 0; k_m = 0; left = 1'b0; done = 1'b0;
        cyc = 0; n_rw = 0; n_dreq = 0; n_dwe = 0; n_pcw = 0;
        wb_rec = 2'b00; ex_aluop = 2'b00; ex_a = 2'b00; ex_b = 1'b0; ex_pcw = 1'b0; ex_pcsrc = 2'b00;
        while (!done && cyc < 40) begin
            instr_opcode = op;
            br_taken     = br;
            imem_ready   = (state_o == S_FETCH) && (k_f == imem_dly);
            dmem_ready   = (state_o == S_MEM) && (k_m == dmem_dly);
            #1;
            if (reg_write) begin n_rw++; wb_rec = wb_sel; end
            if (dmem_req) n_dreq++;
            if (dmem_we)  n_dwe++;
            if (pc_write) n_pcw++;
            if (state_o == S_EXEC) begin
                ex_aluop = ALUOp; ex_a = alu_src_a; ex_b = alu_src_b;
                ex_pcw = pc_write; ex_pcsrc = pc_src;
            end
            if (state_o == S_FETCH) k_f++;
            if (state_o == S_MEM)   k_m++;
            step();
            cyc++;
            if (state_o != S_FETCH) left = 1'b1;
            else if (left) done = 1'b1;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        br_taken   = 1'b0;
        check("run_budget", done, 1);
    endtask

    task automatic expect_run(input string n, input int e_cyc, input int e_rw, input logic [1:0] e_wb,
                              input int e_dreq, input int e_dwe, input int e_pcw);
        check({n, ".cycles"}, cyc, e_cyc);
        check({n, ".reg_write"}, n_rw, e_rw);
        check({n, ".wb_sel"}, wb_rec, e_wb);
        check({n, ".dmem_req"}, n_dreq, e_dreq);
        check({n, ".dmem_we"}, n_dwe, e_dwe);
        check({n, ".pc_write"}, n_pcw, e_pcw);
    endtask

    task automatic expect_exec(input string n, input logic [1:0] e_alu, input logic [1:0] e_a,
                               input logic e_b, input logic e_pcw, input logic [1:0] e_pcsrc);
        check({n, ".ALUOp"}, ex_aluop, e_alu);
        check({n, ".src_a"}, ex_a, e_a);
        check({n, ".src_b"}, ex_b, e_b);
        check({n, ".ex_pcw"}, ex_pcw, e_pcw);
        check({n, ".pc_src"}, ex_pcsrc, e_pcsrc);
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; br_taken = 1'b0; instr_opcode = '0;
        step(); step();
        check("rst.state", state_o, S_RST);
        check("rst.outs", all_outs(), 0);
        check("rst.bus_err", bus_err, 0);
        reset = 1'b0;
        step();
        check("post_rst.state", state_o, S_FETCH);
        check("post_rst.imem_req", imem_req, 1);

        run_instr(OP_R, 0, 0, 1'b0);
        expect_run("r", 4, 1, WB_ALU, 0, 0, 1);
        expect_exec("r", ALU_FUNC, SRCA_RS1, SRCB_RS2, 1'b0, PC_PLUS4);
        run_instr(OP_R, 2, 0, 1'b0);
        check("r_slow.cycles", cyc, 6);
        run_instr(OP_I, 0, 0, 1'b0);
        expect_exec("i", ALU_FUNC, SRCA_RS1, SRCB_IMM, 1'b0, PC_PLUS4);
        run_instr(OP_LOAD, 0, 3, 1'b0);
        expect_run("lw_d3", 8, 1, WB_LOAD, 4, 0, 1);
        expect_exec("lw", ALU_ADD, SRCA_RS1, SRCB_IMM, 1'b0, PC_PLUS4);
        run_instr(OP_LOAD, 0, 4, 1'b0);
        expect_run("lw_ready_at_timeout", 9, 1, WB_LOAD, 5, 0, 1);
        check("lw_ready_at_timeout.bus_err", bus_err, 0);
        run_instr(OP_STORE, 0, 0, 1'b0);
        expect_run("sw", 4, 0, WB_ALU, 1, 1, 1);
        run_instr(OP_BRANCH, 0, 0, 1'b1);
        expect_run("beq_t", 3, 0, WB_ALU, 0, 0, 2);
        expect_exec("beq_t", ALU_BR, SRCA_RS1, SRCB_RS2, 1'b1, PC_TARGET);
        run_instr(OP_BRANCH, 0, 0, 1'b0);
        expect_run("beq_nt", 3, 0, WB_ALU, 0, 0, 1);
        check("beq_nt.ex_pcw", ex_pcw, 0);
        run_instr(OP_JAL, 0, 0, 1'b0);
        expect_run("jal", 4, 1, WB_PC4, 0, 0, 2);
        check("jal.ALUOp", ex_aluop, ALU_PASS);
        check("jal.pc_src", ex_pcsrc, PC_TARGET);
        run_instr(OP_JALR, 0, 0, 1'b0);
        expect_run("jalr", 4, 1, WB_PC4, 0, 0, 2);
        expect_exec("jalr", ALU_ADD, SRCA_RS1, SRCB_IMM, 1'b1, PC_JALR);
        run_instr(OP_LUI, 0, 0, 1'b0);
        expect_exec("lui", ALU_PASS, SRCA_ZERO, SRCB_IMM, 1'b0, PC_PLUS4);
        run_instr(OP_AUIPC, 0, 0, 1'b0);
        expect_exec("auipc", ALU_ADD, SRCA_PC, SRCB_IMM, 1'b0, PC_PLUS4);
        run_instr(OP_FENCE, 0, 0, 1'b0);
        expect_run("fence", 2, 0, WB_ALU, 0, 0, 1);
        run_instr(OP_SYSTEM, 0, 0, 1'b0);
        check("system.cycles", cyc, 2);

        // Fetch timeout: four counted wait cycles, the fifth FETCH cycle times out.
        imem_ready = 1'b0; dmem_ready = 1'b1;
        step(); step(); step(); step();
        check("fetch_to.pre_state", state_o, S_FETCH);
        check("fetch_to.pre_err", bus_err, 0);
        dmem_ready = 1'b0;
        step();
        check("fetch_to.bus_err", bus_err, 1);
        check("fetch_to.state", state_o, S_FETCH);
        check("fetch_to.imem_req", imem_req, 1);
        run_instr(OP_STORE, 0, 0, 1'b0);
        expect_run("sw_after_err", 4, 0, WB_ALU, 1, 1, 1);
        check("sw_after_err.bus_err", bus_err, 1);
        run_instr(OP_LOAD, 0, 99, 1'b0);
        expect_run("lw_mem_to", 8, 0, WB_ALU, 5, 0, 1);

        // Reset while in EXEC aborts without a register write.
        imem_ready = 1'b1; instr_opcode = OP_R;
        step();
        imem_ready = 1'b0;
        step();
        check("abort.state_exec", state_o, S_EXEC);
        reset = 1'b1;
        step();
        check("abort.state", state_o, S_RST);
        check("abort.outs", all_outs(), 0);
        check("abort.bus_err_clr", bus_err, 0);
        reset = 1'b0;
        step();

`ifdef RV_CTRL_TRAP_EN
        imem_ready = 1'b1; instr_opcode = 7'b1111111;
        step();
        imem_ready = 1'b0;
        step();
        check("illegal.state", state_o, S_TRAP);
        imem_ready = 1'b1; dmem_ready = 1'b1;
        step(); step(); step();
        check("illegal.hold", state_o, S_TRAP);
        check("illegal.outs", all_outs(), 1);
        imem_ready = 1'b0; dmem_ready = 1'b0;
        reset = 1'b1;
        step();
        check("illegal.reset", state_o, S_RST);
        check("illegal.trap_clr", trap, 0);
        reset = 1'b0;
        step();
`else
        run_instr(7'b1111111, 0, 0, 1'b0);
        expect_run("illegal", 2, 0, WB_ALU, 0, 0, 1);
        check("illegal.trap", trap, 0);
`endif
        check("end.state", state_o, S_FETCH);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
